// File: rtl/clk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_pkg
// Brief    : Shared types and default constants for the clock/reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILISE = 2'd1,
        RUN       = 2'd2
    } seq_state_t;

    localparam int HOLD_CYCLES = 1024;
    localparam int CPU_DIV     = 8;
    localparam int CNT_W       = 11;
    localparam int SYS_CLK_HZ  = 35464000;

endpackage
`default_nettype wire

// File: rtl/clk_rst_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_rst_seq_if
// Brief    : Lock/reset/enable bundle between the sequencer and the core.
// Revision : 1.0 - initial release
// ============================================================================
interface clk_rst_seq_if #(
    parameter int DIV_W = $clog2(clk_pkg::CPU_DIV)
);
    logic             pll_locked;
    logic             reset_req;
    logic             pause;
    logic             sys_reset;
    logic             ce_cpu;
    logic             ce_2x;
    logic [DIV_W-1:0] div_phase;
    logic             locked_sync;

    // master: the sequencer itself; slave: the PLL/core side that feeds and consumes it
    modport master (
        input  pll_locked, reset_req, pause,
        output sys_reset, ce_cpu, ce_2x, div_phase, locked_sync
    );

    modport slave (
        output pll_locked, reset_req, pause,
        input  sys_reset, ce_cpu, ce_2x, div_phase, locked_sync
    );

endinterface
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Brief    : Generic two-flop synchroniser with async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/clk_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : clk_rst_seq
// Brief    : PLL-lock driven core reset sequencer and clk_sys enable divider.
// Revision : 1.0 - initial release
// ============================================================================
module clk_rst_seq #(
    parameter int HOLD_CYCLES = clk_pkg::HOLD_CYCLES,
    parameter int CPU_DIV     = clk_pkg::CPU_DIV,
    parameter int CNT_W       = clk_pkg::CNT_W
) (
    input  wire logic      clk_sys,
    input  wire logic      rst_n,
    clk_rst_seq_if.master  bus
);
    import clk_pkg::*;

    localparam int c_DIV_W = $clog2(CPU_DIV);

    seq_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [c_DIV_W-1:0] r_div;
    logic               r_sys_reset;
    logic               r_ce_cpu;
    logic               r_ce_2x;

    logic               w_locked;
    logic [c_DIV_W-1:0] w_div_next;
    logic               w_hold_done;
    logic               w_div_wrap;

    sync2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .i_d   (bus.pll_locked),
        .o_q   (w_locked)
    );

    assign w_div_next  = r_div + c_DIV_W'(1);
    assign w_hold_done = (r_cnt == CNT_W'(HOLD_CYCLES - 1));
    assign w_div_wrap  = (r_div == c_DIV_W'(CPU_DIV - 1));

    // Enables and the divider default to idle so any exit from RUN leaves them clean.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_div       <= '0;
            r_sys_reset <= 1'b1;
            r_ce_cpu    <= 1'b0;
            r_ce_2x     <= 1'b0;
        end else begin
            r_ce_cpu <= 1'b0;
            r_ce_2x  <= 1'b0;
            r_div    <= '0;
            case (r_state)
                WAIT_LOCK: begin
                    r_sys_reset <= 1'b1;
                    r_cnt       <= '0;
                    if (w_locked) begin
                        r_state <= STABILISE;
                    end
                end
                STABILISE: begin
                    r_sys_reset <= 1'b1;
                    if (!w_locked) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (bus.reset_req) begin
                        r_cnt <= '0;
                    end else if (w_hold_done) begin
                        r_state     <= RUN;
                        r_cnt       <= '0;
                        r_sys_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    r_cnt <= '0;
                    if (!w_locked) begin
                        r_state     <= WAIT_LOCK;
                        r_sys_reset <= 1'b1;
                    end else if (bus.reset_req) begin
                        r_state     <= STABILISE;
                        r_sys_reset <= 1'b1;
                    end else begin
                        // ce_cpu lands on the cycle the divider returns to phase 0
                        r_sys_reset <= 1'b0;
                        r_div       <= w_div_next;
                        r_ce_cpu    <= w_div_wrap && !bus.pause;
                        r_ce_2x     <= w_div_next[0];
                    end
                end
                default: begin
                    r_state     <= WAIT_LOCK;
                    r_cnt       <= '0;
                    r_sys_reset <= 1'b1;
                end
            endcase
        end
    end

    assign bus.sys_reset   = r_sys_reset;
    assign bus.ce_cpu      = r_ce_cpu;
    assign bus.ce_2x       = r_ce_2x;
    assign bus.div_phase   = r_div;
    assign bus.locked_sync = w_locked;

endmodule
`default_nettype wire

// File: tb/tb_clk_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_rst_seq
// Brief    : Directed self-checking bench for the clock/reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clk_rst_seq;

    localparam int c_HOLD = 1024;
    localparam int c_DIV  = 8;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   run_k   = 0;

    clk_rst_seq_if #(.DIV_W(3)) bus ();

    clk_rst_seq #(
        .HOLD_CYCLES (c_HOLD),
        .CPU_DIV     (c_DIV),
        .CNT_W       (11)
    ) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Expected {ce_cpu, ce_2x, div_phase} k cycles after sys_reset fell.
    function automatic logic [4:0] run_model(int k, logic paused);
        logic [2:0] ph;
        ph = 3'(k % c_DIV);
        return {(k != 0) && (ph == 3'd0) && !paused, ph[0], ph};
    endfunction

    task automatic test_reset();
        bus.pll_locked = 1'b0;
        bus.reset_req  = 1'b0;
        bus.pause      = 1'b0;
        rst_n          = 1'b0;
        repeat (5) tick();
        checks++;
        if (bus.sys_reset !== 1'b1) begin
            errors++; $display("FAIL reset_sys_reset: got %b expected 1", bus.sys_reset);
        end
        checks++;
        if ({bus.ce_cpu, bus.ce_2x, bus.div_phase} !== 5'b0) begin
            errors++; $display("FAIL reset_enables: got %b expected 00000", {bus.ce_cpu, bus.ce_2x, bus.div_phase});
        end
        checks++;
        if (bus.locked_sync !== 1'b0) begin
            errors++; $display("FAIL reset_locked_sync: got %b expected 0", bus.locked_sync);
        end
        bus.pll_locked = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.locked_sync !== 1'b0) begin
            errors++; $display("FAIL reset_sync_held: got %b expected 0", bus.locked_sync);
        end
        bus.pll_locked = 1'b0;
        tick();
    endtask

    task automatic test_power_up();
        int bad;
        logic [4:0] want;
        rst_n = 1'b1;
        repeat (10) tick();
        checks++;
        if ({bus.sys_reset, bus.locked_sync} !== 2'b10) begin
            errors++; $display("FAIL pwr_wait_lock: got %b expected 10", {bus.sys_reset, bus.locked_sync});
        end
        bus.pll_locked = 1'b1;
        tick();
        checks++;
        if (bus.locked_sync !== 1'b0) begin
            errors++; $display("FAIL pwr_sync_lat1: got %b expected 0", bus.locked_sync);
        end
        tick();
        checks++;
        if (bus.locked_sync !== 1'b1) begin
            errors++; $display("FAIL pwr_sync_lat2: got %b expected 1", bus.locked_sync);
        end
        bad = 0;
        for (int i = 0; i < c_HOLD; i++) begin
            tick();
            if (bus.sys_reset !== 1'b1 || bus.ce_cpu !== 1'b0 || bus.ce_2x !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL pwr_hold: %0d bad cycles, expected 0", bad);
        end
        tick();
        checks++;
        if ({bus.sys_reset, bus.ce_cpu, bus.ce_2x, bus.div_phase} !== 6'b0) begin
            errors++; $display("FAIL pwr_release: got %b expected 000000", {bus.sys_reset, bus.ce_cpu, bus.ce_2x, bus.div_phase});
        end
        run_k = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            run_k++;
            want = run_model(run_k, 1'b0);
            checks++;
            if ({bus.ce_cpu, bus.ce_2x, bus.div_phase} !== want) begin
                errors++; $display("FAIL pwr_run k=%0d: got %b expected %b", run_k, {bus.ce_cpu, bus.ce_2x, bus.div_phase}, want);
            end
        end
    endtask

    task automatic test_pause();
        logic p;
        logic [4:0] want;
        for (int i = 0; i < 32; i++) begin
            p = (i < 20);
            bus.pause = p;
            tick();
            run_k++;
            want = run_model(run_k, p);
            checks++;
            if ({bus.ce_cpu, bus.ce_2x, bus.div_phase} !== want) begin
                errors++; $display("FAIL pause k=%0d: got %b expected %b", run_k, {bus.ce_cpu, bus.ce_2x, bus.div_phase}, want);
            end
        end
        bus.pause = 1'b0;
    endtask

    task automatic test_reset_req_pulse();
        int bad;
        logic [4:0] want;
        bus.reset_req = 1'b1;
        tick();
        bus.reset_req = 1'b0;
        checks++;
        if ({bus.sys_reset, bus.ce_cpu, bus.ce_2x, bus.div_phase} !== 6'b100000) begin
            errors++; $display("FAIL req_enter: got %b expected 100000", {bus.sys_reset, bus.ce_cpu, bus.ce_2x, bus.div_phase});
        end
        bad = 0;
        for (int i = 0; i < c_HOLD - 1; i++) begin
            tick();
            if ({bus.sys_reset, bus.ce_cpu, bus.ce_2x, bus.div_phase} !== 6'b100000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL req_hold: %0d bad cycles, expected 0", bad);
        end
        tick();
        checks++;
        if ({bus.sys_reset, bus.div_phase} !== 4'b0000) begin
            errors++; $display("FAIL req_release: got %b expected 0000", {bus.sys_reset, bus.div_phase});
        end
        run_k = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            run_k++;
            want = run_model(run_k, 1'b0);
            checks++;
            if ({bus.ce_cpu, bus.ce_2x, bus.div_phase} !== want) begin
                errors++; $display("FAIL req_run k=%0d: got %b expected %b", run_k, {bus.ce_cpu, bus.ce_2x, bus.div_phase}, want);
            end
        end
    endtask

    task automatic test_lock_loss();
        int bad;
        logic [4:0] want;
        bus.pll_locked = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            run_k++;
            want = run_model(run_k, 1'b0);
            checks++;
            if ({bus.sys_reset, bus.ce_cpu, bus.ce_2x, bus.div_phase} !== {1'b0, want}) begin
                errors++; $display("FAIL loss_drain%0d: got %b expected %b", i, {bus.sys_reset, bus.ce_cpu, bus.ce_2x, bus.div_phase}, {1'b0, want});
            end
        end
        checks++;
        if (bus.locked_sync !== 1'b0) begin
            errors++; $display("FAIL loss_sync: got %b expected 0", bus.locked_sync);
        end
        tick();
        bus.pll_locked = 1'b1;
        checks++;
        if ({bus.sys_reset, bus.ce_cpu, bus.ce_2x, bus.div_phase} !== 6'b100000) begin
            errors++; $display("FAIL loss_reset: got %b expected 100000", {bus.sys_reset, bus.ce_cpu, bus.ce_2x, bus.div_phase});
        end
        tick();
        checks++;
        if (bus.locked_sync !== 1'b0) begin
            errors++; $display("FAIL relock_lat1: got %b expected 0", bus.locked_sync);
        end
        tick();
        checks++;
        if (bus.locked_sync !== 1'b1) begin
            errors++; $display("FAIL relock_lat2: got %b expected 1", bus.locked_sync);
        end
        bad = 0;
        for (int i = 0; i < c_HOLD; i++) begin
            tick();
            if ({bus.sys_reset, bus.ce_cpu, bus.ce_2x, bus.div_phase} !== 6'b100000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL relock_hold: %0d bad cycles, expected 0", bad);
        end
        tick();
        checks++;
        if (bus.sys_reset !== 1'b0) begin
            errors++; $display("FAIL relock_release: got %b expected 0", bus.sys_reset);
        end
        run_k = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            run_k++;
            want = run_model(run_k, 1'b0);
            checks++;
            if ({bus.ce_cpu, bus.ce_2x, bus.div_phase} !== want) begin
                errors++; $display("FAIL relock_run k=%0d: got %b expected %b", run_k, {bus.ce_cpu, bus.ce_2x, bus.div_phase}, want);
            end
        end
    endtask

    task automatic test_reset_req_hold();
        int bad;
        bus.reset_req = 1'b1;
        bad = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (bus.sys_reset !== 1'b1 || bus.ce_cpu !== 1'b0 || bus.ce_2x !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL hold_req_high: %0d bad cycles, expected 0", bad);
        end
        bus.reset_req = 1'b0;
        bad = 0;
        for (int i = 0; i < c_HOLD - 1; i++) begin
            tick();
            if (bus.sys_reset !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL hold_req_after: %0d bad cycles, expected 0", bad);
        end
        tick();
        checks++;
        if ({bus.sys_reset, bus.div_phase} !== 4'b0000) begin
            errors++; $display("FAIL hold_req_release: got %b expected 0000", {bus.sys_reset, bus.div_phase});
        end
    endtask

    task automatic test_async_reset();
        int bad;
        logic [4:0] want;
        // Let the divider reach a non-zero phase first
        repeat (3) tick();
        @(posedge clk_sys);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.sys_reset, bus.ce_cpu, bus.ce_2x, bus.div_phase, bus.locked_sync} !== 7'b1000000) begin
            errors++; $display("FAIL async_immediate: got %b expected 1000000", {bus.sys_reset, bus.ce_cpu, bus.ce_2x, bus.div_phase, bus.locked_sync});
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bus.sys_reset, bus.locked_sync} !== 2'b10) begin
            errors++; $display("FAIL async_resync1: got %b expected 10", {bus.sys_reset, bus.locked_sync});
        end
        tick();
        checks++;
        if (bus.locked_sync !== 1'b1) begin
            errors++; $display("FAIL async_resync2: got %b expected 1", bus.locked_sync);
        end
        bad = 0;
        for (int i = 0; i < c_HOLD; i++) begin
            tick();
            if ({bus.sys_reset, bus.ce_cpu, bus.ce_2x, bus.div_phase} !== 6'b100000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL async_hold: %0d bad cycles, expected 0", bad);
        end
        tick();
        checks++;
        if (bus.sys_reset !== 1'b0) begin
            errors++; $display("FAIL async_release: got %b expected 0", bus.sys_reset);
        end
        run_k = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            run_k++;
            want = run_model(run_k, 1'b0);
            checks++;
            if ({bus.ce_cpu, bus.ce_2x, bus.div_phase} !== want) begin
                errors++; $display("FAIL async_run k=%0d: got %b expected %b", run_k, {bus.ce_cpu, bus.ce_2x, bus.div_phase}, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_pause();
        test_reset_req_pulse();
        test_lock_loss();
        test_reset_req_hold();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
